fetch_unit: RTL and testbench

Instruction fetch controller for the pipelined RISC-V core. It owns the program counter and drives the word address of the combinational instruction ROM. It captures each returned instruction word with its PC into a 2-entry buffer and hands them to decode over a valid/ready handshake. Branch and jump redirects arrive from execute and flush the buffer.

---
 rtl/core_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// core_pkg : shared fetch-stage types and constants
// Rev 1.0
// ------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_buffer : 2-entry FIFO of {pc, instr} with flush
// Rev 1.0
// ------------------------------------------------------------------
module fetch_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [31:0]           i_push_pc,
  input  logic [DATA_WIDTH-1:0] i_push_instr,
  output logic [1:0]            o_count,
  output logic [31:0]           o_head_pc,
  output logic [DATA_WIDTH-1:0] o_head_instr
);

  logic [31:0]           r_pc_mem    [2];
  logic [DATA_WIDTH-1:0] r_instr_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_pop;
  logic                  w_push;

  // Guard against misuse so count can never leave 0..2
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_mem[0]    <= '0;
      r_pc_mem[1]    <= '0;
      r_instr_mem[0] <= '0;
      r_instr_mem[1] <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= i_push_pc;
        r_instr_mem[r_wr_ptr] <= i_push_instr;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_count      = r_count;
  assign o_head_pc    = r_pc_mem[r_rd_ptr];
  assign o_head_instr = r_instr_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_unit : PC, fetch FSM and decode handshake for the RISC-V core
// Rev 1.0
// ------------------------------------------------------------------
module fetch_unit
  import core_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [31:0]           if_pc
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [1:0]   w_count;
  logic         w_pop;
  logic         w_push;
  logic         w_unused;

  assign w_unused = &{1'b0, redirect_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH_BOOT: w_state_nxt = fetch_en ? FETCH_RUN : FETCH_HALT;
      FETCH_RUN:  if (!fetch_en) w_state_nxt = FETCH_HALT;
      FETCH_HALT: if (fetch_en) w_state_nxt = FETCH_RUN;
      default:    w_state_nxt = FETCH_BOOT;
    endcase
  end

  assign if_valid = (w_count != 2'd0);
  assign w_pop    = if_valid && if_ready;
  // A full buffer can still accept when the head leaves in the same cycle
  assign w_push   = (r_state == FETCH_RUN) && !redirect_valid &&
                    ((w_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign imem_addr = r_pc[ADDR_WIDTH+1:2];

  fetch_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fetch_buffer (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .i_push_pc    (r_pc),
    .i_push_instr (imem_data),
    .o_count      (w_count),
    .o_head_pc    (if_pc),
    .o_head_instr (if_instr)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fetch_unit : directed stimulus, queue-based reference model
// Rev 1.0
// ------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b1;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] rom [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetching is allowed once a clock edge has passed since
  // reset and fetch_en was high at the previous edge; entries are {pc, instr}.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_seen_edge;
  bit          m_last_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pc        = RST_PC;
      m_seen_edge = 1'b0;
      m_last_en   = 1'b0;
    end else begin
      bit run;
      bit pop;
      int n;
      run = m_seen_edge && m_last_en;
      n   = m_q.size();
      pop = (n > 0) && if_ready;
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (run && (n < 2 || pop)) begin
          m_q.push_back({m_pc, rom[(m_pc >> 2) % 256]});
          m_pc = m_pc + 32'd4;
        end
      end
      m_seen_edge = 1'b1;
      m_last_en   = fetch_en;
    end
  end

  always @(negedge clk) begin
    chk("model_valid", {31'b0, if_valid}, {31'b0, (m_q.size() != 0)});
    chk("model_addr", {24'b0, imem_addr}, (m_pc >> 2) % 256);
    if (m_q.size() != 0) begin
      chk("model_pc", if_pc, m_q[0][63:32]);
      chk("model_instr", if_instr, m_q[0][31:0]);
    end else if (rst) begin
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_instr", if_instr, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #4;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
    rom[1] = 32'h1000_2503;
    rom[2] = 32'h1000_1583;

    // Reset release and first two instructions
    step(); step();
    chk("reset_valid", {31'b0, if_valid}, 32'd0);
    chk("reset_addr", {24'b0, imem_addr}, 32'd1);
    chk("reset_if_pc", if_pc, 32'd0);
    rst = 1'b0;                       // cycle 0 (BOOT)
    step();                           // cycle 1
    chk("c1_valid", {31'b0, if_valid}, 32'd0);
    step();                           // cycle 2
    chk("c2_pc", if_pc, 32'h4);
    chk("c2_instr", if_instr, 32'h1000_2503);
    step();                           // cycle 3
    chk("c3_pc", if_pc, 32'h8);
    chk("c3_instr", if_instr, 32'h1000_1583);

    // Backpressure for 5 cycles starting at cycle 2
    rst = 1'b1; step(); rst = 1'b0;   // cycle 0
    step(); step();                   // cycle 2
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin // cycles 3..6
      step();
      chk("stall_addr", {24'b0, imem_addr}, 32'd3);
      chk("stall_pc", if_pc, 32'h4);
    end
    step();                           // cycle 7
    if_ready = 1'b1;
    chk("rel_pc0", if_pc, 32'h4);
    step();
    chk("rel_pc1", if_pc, 32'h8);
    step();                           // cycle 9
    chk("rel_pc2", if_pc, 32'hC);

    // Redirect with same-cycle pop
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_001E;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'b0, if_valid}, 32'd0);
    chk("redir_addr", {24'b0, imem_addr}, 32'd7);
    step();
    chk("redir_pc", if_pc, 32'h1C);
    chk("redir_instr", if_instr, 32'hC0DE_0007);
    step();
    chk("redir_next", if_pc, 32'h20);

    // fetch_en low for 3 cycles
    fetch_en = 1'b0;
    step();
    chk("halt_addr0", {24'b0, imem_addr}, 32'd10);
    chk("halt_pc", if_pc, 32'h24);
    step();
    chk("halt_addr1", {24'b0, imem_addr}, 32'd10);
    chk("halt_drain", {31'b0, if_valid}, 32'd0);
    step();
    chk("halt_addr2", {24'b0, imem_addr}, 32'd10);
    fetch_en = 1'b1;
    step();
    chk("resume_wait", {31'b0, if_valid}, 32'd0);
    step();
    chk("resume_pc", if_pc, 32'h28);
    chk("resume_instr", if_instr, 32'hC0DE_000A);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr_top", {24'b0, imem_addr}, 32'hFF);
    step();
    chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
    chk("wrap_instr_top", if_instr, 32'hC0DE_00FF);
    chk("wrap_addr0", {24'b0, imem_addr}, 32'd0);
    step();
    chk("wrap_pc0", if_pc, 32'h0);
    chk("wrap_instr0", if_instr, 32'hC0DE_0000);

    // Asynchronous reset with a full buffer
    if_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_instr", if_instr, 32'd0);
    chk("arst_addr", {24'b0, imem_addr}, 32'd1);
    if_ready = 1'b1;
    step();
    rst = 1'b0;                       // cycle 0 (BOOT)
    step();
    chk("reboot_c1", {31'b0, if_valid}, 32'd0);
    step();
    chk("reboot_c2", if_pc, 32'h4);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
